// File: rtl/turn_controller.sv
// turn_controller: sequences one checkers turn (pick, legal-move capture, confirm, engine command).
// Defining TURN_TIMER_EN adds a per-turn tick budget with forced turn hand-over on expiry.
module turn_controller #(
  parameter bit FIRST_RED = 1'b1,
  parameter int TURN_TIME = 30
) (
  input  logic         clk,
  input  logic         rst,
`ifdef TURN_TIMER_EN
  input  logic         tick,
  output logic [7:0]   time_left,
  output logic         timeout,
`endif
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         btn_sel,
  input  logic         btn_cancel,
  input  logic [191:0] board,
  input  logic [27:0]  legal_move,
  input  logic         engine_busy,
  input  logic         cmd_ready,
  output logic [5:0]   select_loc,
  output logic [5:0]   cursor,
  output logic [5:0]   src_loc,
  output logic [5:0]   dst_loc,
  output logic         cmd_valid,
  output logic         turn_red,
  output logic         err_pulse,
  output logic [2:0]   state_dbg
);

  typedef enum logic [2:0] {
    PICK  = 3'd0,
    ARM1  = 3'd1,
    ARM2  = 3'd2,
    DEST  = 3'd3,
    ISSUE = 3'd4,
    WAIT  = 3'd5,
    NEXT  = 3'd6
  } state_t;

  state_t      state, state_next;
  logic [5:0]  cursor_next, src_next, dst_next;
  logic [27:0] legal_q, legal_next;
  logic        err_next, turn_next;
  logic        wait_seen, wait_seen_next;
  logic [2:0]  pick_cell;
  logic        any_legal, dest_hit;
  logic        unused_king;

  assign unused_king = pick_cell[0];
  assign state_dbg   = state;

  always_comb begin
    cursor_next = cursor;
    if (state == PICK || state == DEST) begin
      if (btn_up) begin
        if (cursor[2:0] != 3'd7) cursor_next[2:0] = cursor[2:0] + 3'd1;
      end else if (btn_down) begin
        if (cursor[2:0] != 3'd0) cursor_next[2:0] = cursor[2:0] - 3'd1;
      end else if (btn_left) begin
        if (cursor[5:3] != 3'd0) cursor_next[5:3] = cursor[5:3] - 3'd1;
      end else if (btn_right) begin
        if (cursor[5:3] != 3'd7) cursor_next[5:3] = cursor[5:3] + 3'd1;
      end
    end
  end

  // any_legal looks at the live engine slots (ARM2); dest_hit at the captured copy (DEST)
  always_comb begin
    any_legal = 1'b0;
    dest_hit  = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (legal_move[7*s+6]) any_legal = 1'b1;
      if (legal_q[7*s+6] && (legal_q[7*s +: 6] == cursor)) dest_hit = 1'b1;
    end
  end

`ifdef TURN_TIMER_EN
  logic timer_run, timeout_hit;

  assign timer_run   = (state == PICK) || (state == ARM1) || (state == ARM2) || (state == DEST);
  assign timeout_hit = timer_run && tick && (time_left == 8'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      time_left <= 8'(TURN_TIME);
      timeout   <= 1'b0;
    end else begin
      timeout <= timeout_hit;
      if (timeout_hit || state == NEXT)
        time_left <= 8'(TURN_TIME);
      else if (timer_run && tick)
        time_left <= time_left - 8'd1;
    end
  end
`else
  logic [7:0] unused_turn_time;
  assign unused_turn_time = 8'(TURN_TIME);
`endif

  always_comb begin
    state_next     = state;
    src_next       = src_loc;
    dst_next       = dst_loc;
    legal_next     = legal_q;
    err_next       = 1'b0;
    turn_next      = turn_red;
    wait_seen_next = wait_seen;
    pick_cell      = board[3*cursor +: 3];
    case (state)
      PICK: begin
        if (btn_sel) begin
          if (pick_cell[2] && (pick_cell[1] == turn_red)) begin
            src_next   = cursor;
            state_next = ARM1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ARM1: state_next = ARM2;
      ARM2: begin
        legal_next = legal_move;
        if (any_legal) begin
          state_next = DEST;
        end else begin
          err_next   = 1'b1;
          state_next = PICK;
        end
      end
      DEST: begin
        if (btn_cancel) begin
          state_next = PICK;
        end else if (btn_sel) begin
          if (dest_hit) begin
            dst_next   = cursor;
            state_next = ISSUE;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          wait_seen_next = 1'b0;
          state_next     = WAIT;
        end
      end
      // The engine only raises busy the cycle after accept, so the first WAIT cycle is skipped
      WAIT: begin
        if (!wait_seen)
          wait_seen_next = 1'b1;
        else if (!engine_busy)
          state_next = NEXT;
      end
      NEXT: begin
        turn_next  = ~turn_red;
        state_next = PICK;
      end
      default: state_next = PICK;
    endcase
`ifdef TURN_TIMER_EN
    if (timeout_hit) begin
      state_next = PICK;
      err_next   = 1'b0;
      turn_next  = ~turn_red;
      src_next   = src_loc;
      dst_next   = dst_loc;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PICK;
      cursor     <= '0;
      src_loc    <= '0;
      dst_loc    <= '0;
      select_loc <= '0;
      cmd_valid  <= 1'b0;
      err_pulse  <= 1'b0;
      turn_red   <= FIRST_RED;
      legal_q    <= '0;
      wait_seen  <= 1'b0;
    end else begin
      state      <= state_next;
      cursor     <= cursor_next;
      src_loc    <= src_next;
      dst_loc    <= dst_next;
      select_loc <= (state_next == PICK || state_next == DEST) ? cursor_next : src_next;
      cmd_valid  <= (state_next == ISSUE);
      err_pulse  <= err_next;
      turn_red   <= turn_next;
      legal_q    <= legal_next;
      wait_seen  <= wait_seen_next;
    end
  end

endmodule

// File: tb/tb_turn_controller.sv
// tb_turn_controller: directed turn sequences checked every cycle against a behavioural turn model.
// Build with TURN_TIMER_EN defined to also exercise the per-turn timer.
module tb_turn_controller;

`ifdef TURN_TIMER_EN
  localparam int TB_TURN_TIME = 3;
`else
  localparam int TB_TURN_TIME = 30;
`endif

  localparam logic [5:0] B_NONE = 6'b000000;
  localparam logic [5:0] B_UP   = 6'b100000;
  localparam logic [5:0] B_DN   = 6'b010000;
  localparam logic [5:0] B_LT   = 6'b001000;
  localparam logic [5:0] B_RT   = 6'b000100;
  localparam logic [5:0] B_SEL  = 6'b000010;
  localparam logic [5:0] B_CAN  = 6'b000001;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic         btn_up, btn_down, btn_left, btn_right, btn_sel, btn_cancel;
  logic [191:0] board;
  logic [27:0]  legal_move;
  logic         engine_busy, cmd_ready;
  logic [5:0]   select_loc, cursor, src_loc, dst_loc;
  logic         cmd_valid, turn_red, err_pulse;
  logic [2:0]   state_dbg;
  logic [7:0]   time_left;
  logic         timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  turn_controller #(.FIRST_RED(1'b1), .TURN_TIME(TB_TURN_TIME)) dut (
    .clk(clk), .rst(rst),
`ifdef TURN_TIMER_EN
    .tick(tick), .time_left(time_left), .timeout(timeout),
`endif
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_sel(btn_sel), .btn_cancel(btn_cancel), .board(board), .legal_move(legal_move),
    .engine_busy(engine_busy), .cmd_ready(cmd_ready), .select_loc(select_loc),
    .cursor(cursor), .src_loc(src_loc), .dst_loc(dst_loc), .cmd_valid(cmd_valid),
    .turn_red(turn_red), .err_pulse(err_pulse), .state_dbg(state_dbg)
  );

`ifndef TURN_TIMER_EN
  assign time_left = 8'd0;
  assign timeout   = 1'b0;
`endif

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: phase number, cursor as integer coordinates, legal squares by lookup
  int         m_st, mn, m_cx, m_cy, m_wait_n, m_time;
  logic [5:0] m_src, m_dst, osrc, odst;
  logic [27:0] m_legal;
  logic       m_turn, m_err, m_tout;
  bit         m_live = 0;

  function automatic logic [5:0] packXY(int x, int y);
    return {3'(x), 3'(y)};
  endfunction

  function automatic logic [2:0] cellAt(int x, int y);
    return board[3*(8*x+y) +: 3];
  endfunction

  function automatic bit legalHas(logic [27:0] lv, int x, int y);
    for (int s = 0; s < 4; s++)
      if (lv[7*s+6] && lv[7*s +: 6] == packXY(x, y)) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_st = 0; m_cx = 0; m_cy = 0; m_src = '0; m_dst = '0; m_legal = '0;
      m_turn = 1'b1; m_err = 1'b0; m_wait_n = 0; m_time = TB_TURN_TIME; m_tout = 1'b0;
      m_live = 1;
    end else if (m_live) begin
      mn = m_st; m_err = 1'b0; osrc = m_src; odst = m_dst;
      case (m_st)
        0: if (btn_sel) begin
             if (cellAt(m_cx, m_cy)[2] && cellAt(m_cx, m_cy)[1] == m_turn) begin
               m_src = packXY(m_cx, m_cy); mn = 1;
             end else m_err = 1'b1;
           end
        1: mn = 2;
        2: begin
             m_legal = legal_move;
             if (legalHas(legal_move, 0, 0) || legal_move[6] || legal_move[13] ||
                 legal_move[20] || legal_move[27]) mn = 3;
             else begin m_err = 1'b1; mn = 0; end
           end
        3: if (btn_cancel) mn = 0;
           else if (btn_sel) begin
             if (legalHas(m_legal, m_cx, m_cy)) begin m_dst = packXY(m_cx, m_cy); mn = 4; end
             else m_err = 1'b1;
           end
        4: if (cmd_ready) begin mn = 5; m_wait_n = 0; end
        5: begin m_wait_n++; if (m_wait_n >= 2 && !engine_busy) mn = 6; end
        6: begin m_turn = !m_turn; mn = 0; end
        default: mn = 0;
      endcase
      if (m_st == 0 || m_st == 3) begin
        if (btn_up) m_cy = (m_cy < 7) ? m_cy + 1 : 7;
        else if (btn_down) m_cy = (m_cy > 0) ? m_cy - 1 : 0;
        else if (btn_left) m_cx = (m_cx > 0) ? m_cx - 1 : 0;
        else if (btn_right) m_cx = (m_cx < 7) ? m_cx + 1 : 7;
      end
`ifdef TURN_TIMER_EN
      m_tout = 1'b0;
      if (m_st == 6) m_time = TB_TURN_TIME;
      else if (m_st <= 3 && tick) begin
        m_time--;
        if (m_time == 0) begin
          m_tout = 1'b1; mn = 0; m_err = 1'b0; m_turn = !m_turn;
          m_src = osrc; m_dst = odst; m_time = TB_TURN_TIME;
        end
      end
`endif
      m_st = mn;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      checkOutput("state_dbg", state_dbg, m_st);
      checkOutput("cursor", cursor, packXY(m_cx, m_cy));
      checkOutput("src_loc", src_loc, m_src);
      checkOutput("dst_loc", dst_loc, m_dst);
      checkOutput("cmd_valid", cmd_valid, (m_st == 4));
      checkOutput("turn_red", turn_red, m_turn);
      checkOutput("err_pulse", err_pulse, m_err);
      checkOutput("select_loc", select_loc, (m_st == 0 || m_st == 3) ? packXY(m_cx, m_cy) : m_src);
`ifdef TURN_TIMER_EN
      checkOutput("time_left", time_left, m_time);
      checkOutput("timeout", timeout, m_tout);
`endif
    end
  end

  task automatic applyStimulus(input logic [5:0] btn, input logic rdy, input logic busy, input logic tk);
    {btn_up, btn_down, btn_left, btn_right, btn_sel, btn_cancel} = btn;
    cmd_ready = rdy; engine_busy = busy; tick = tk;
    @(posedge clk); #1;
    {btn_up, btn_down, btn_left, btn_right, btn_sel, btn_cancel} = B_NONE;
    cmd_ready = 1'b0; tick = 1'b0;
  endtask

  task automatic press(input logic [5:0] btn, input int n);
    for (int i = 0; i < n; i++) applyStimulus(btn, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic waitState(input logic [2:0] target, input int budget);
    int k = 0;
    while (state_dbg != target && k < budget) begin
      applyStimulus(B_NONE, 1'b0, 1'b0, 1'b0);
      k++;
    end
    checkOutput("wait_state", state_dbg, target);
  endtask

  task automatic doReset();
    rst = 1'b1;
    press(B_NONE, 2);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; cmd_ready = 1'b0; engine_busy = 1'b0;
    {btn_up, btn_down, btn_left, btn_right, btn_sel, btn_cancel} = B_NONE;
    board = '0;
    board[3*(8*2+2) +: 3] = 3'b110;
    board[3*(8*5+5) +: 3] = 3'b100;
    legal_move = {21'd0, 7'b1_001_011};

    // reset state
    press(B_NONE, 2);
    rst = 1'b0;
    checkOutput("rst state", state_dbg, 3'd0);
    checkOutput("rst turn", turn_red, 1'b1);
    checkOutput("rst cursor", cursor, 6'o00);
    checkOutput("rst cmd_valid", cmd_valid, 1'b0);
    checkOutput("rst err", err_pulse, 1'b0);

    // full red move (2,2) -> (1,3)
    press(B_RT, 2); press(B_UP, 2);
    press(B_SEL, 1);
    checkOutput("arm1 state", state_dbg, 3'd1);
    press(B_NONE, 2);
    checkOutput("dest state", state_dbg, 3'd3);
    press(B_LT, 1); press(B_UP, 1); press(B_SEL, 1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("issue valid", cmd_valid, 1'b1);
      checkOutput("issue src", src_loc, 6'o22);
      checkOutput("issue dst", dst_loc, 6'o13);
      press(B_NONE, 1);
    end
    applyStimulus(B_NONE, 1'b1, 1'b0, 1'b0);
    checkOutput("xfer valid drop", cmd_valid, 1'b0);
    checkOutput("wait state", state_dbg, 3'd5);
    applyStimulus(B_NONE, 1'b0, 1'b1, 1'b0);
    applyStimulus(B_NONE, 1'b0, 1'b1, 1'b0);
    checkOutput("wait busy", state_dbg, 3'd5);
    waitState(3'd0, 6);
    checkOutput("turn toggled", turn_red, 1'b0);

    // white piece while red to move
    doReset();
    press(B_RT, 5); press(B_UP, 5);
    press(B_SEL, 1);
    checkOutput("wrong colour err", err_pulse, 1'b1);
    checkOutput("wrong colour state", state_dbg, 3'd0);
    press(B_NONE, 1);
    checkOutput("err one cycle", err_pulse, 1'b0);

    // saturation and priority
    press(B_RT, 2); press(B_UP, 2);
    checkOutput("corner", cursor, 6'o77);
    press(B_UP, 1);
    checkOutput("saturate up", cursor, 6'o77);
    press(B_RT, 1);
    checkOutput("saturate right", cursor, 6'o77);
    press(B_LT, 4); press(B_DN, 4);
    press(B_UP | B_LT, 1);
    checkOutput("up beats left", cursor, 6'o34);

    // bad destination, then cancel beats sel
    press(B_LT, 1); press(B_DN, 2);
    press(B_SEL, 1); press(B_NONE, 2);
    checkOutput("dest again", state_dbg, 3'd3);
    press(B_SEL, 1);
    checkOutput("bad dst err", err_pulse, 1'b1);
    checkOutput("bad dst state", state_dbg, 3'd3);
    press(B_SEL | B_CAN, 1);
    checkOutput("cancel state", state_dbg, 3'd0);
    checkOutput("cancel no err", err_pulse, 1'b0);

    // reset mid-handshake
    press(B_SEL, 1); press(B_NONE, 2);
    press(B_LT, 1); press(B_UP, 1); press(B_SEL, 1);
    checkOutput("issue before rst", cmd_valid, 1'b1);
    rst = 1'b1;
    press(B_NONE, 1);
    rst = 1'b0;
    checkOutput("rst drops valid", cmd_valid, 1'b0);
    checkOutput("rst to pick", state_dbg, 3'd0);

    // no legal slot from the engine
    legal_move = '0;
    press(B_RT, 2); press(B_UP, 2);
    press(B_SEL, 1); press(B_NONE, 2);
    checkOutput("no legal err", err_pulse, 1'b1);
    checkOutput("no legal state", state_dbg, 3'd0);
    legal_move = {21'd0, 7'b1_001_011};

`ifdef TURN_TIMER_EN
    press(B_SEL, 1); press(B_NONE, 2);
    checkOutput("timer dest", state_dbg, 3'd3);
    applyStimulus(B_NONE, 1'b0, 1'b0, 1'b1);
    applyStimulus(B_NONE, 1'b0, 1'b0, 1'b1);
    checkOutput("time_left 1", time_left, 8'd1);
    applyStimulus(B_SEL, 1'b0, 1'b0, 1'b1);
    checkOutput("timeout pulse", timeout, 1'b1);
    checkOutput("timeout turn", turn_red, 1'b0);
    checkOutput("timeout state", state_dbg, 3'd0);
    checkOutput("timeout reload", time_left, 8'd3);
    press(B_NONE, 1);
    checkOutput("timeout one cycle", timeout, 1'b0);
`endif

    press(B_NONE, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
